// File: rtl/wb_sram_responder.sv
// Pipelined Wishbone responder backed by a word-organised synchronous RAM.
// Optional stall injection: define WB_RESPONDER_STALL_INJECT_EN.
module wb_sram_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter string       INIT_FILE   = "",
  parameter logic [15:0] STALL_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  output logic        stall,
  output logic        ack,
  input  logic [31:0] adr,
  input  logic [3:0]  sel,
  input  logic        we,
  input  logic [31:0] dat_w,
  output logic [31:0] dat_r
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0]        r_mem [DEPTH_WORDS];
  logic [LATENCY-1:0] r_vld;
  logic [31:0]        r_dat [LATENCY];

  logic          w_accept;
  logic [AW-1:0] w_idx;
  logic          w_unused_adr;

  assign w_idx        = adr[2 +: AW];
  assign w_accept     = stb & ~stall & ~rst;
  // Byte offset and bits above the index are deliberately ignored so addresses wrap.
  assign w_unused_adr = ^{adr[1:0], adr[31:2+AW]};

  // RAM is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (w_accept && we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (sel[i]) r_mem[w_idx][8*i +: 8] <= dat_w[8*i +: 8];
      end
    end
  end

  // Invalid stages carry zero data, so dat_r is 0 whenever ack is low and for write acks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) r_dat[i] <= '0;
    end else begin
      r_vld[0] <= w_accept;
      r_dat[0] <= (w_accept && !we) ? r_mem[w_idx] : '0;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign ack   = r_vld[LATENCY-1];
  assign dat_r = r_dat[LATENCY-1];

`ifdef WB_RESPONDER_STALL_INJECT_EN
  logic [15:0] r_lfsr;
  logic        r_stall;
  logic        w_fb;

  // Fibonacci LFSR, taps x^16 + x^14 + x^13 + x^11 + 1.
  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr  <= STALL_SEED;
      r_stall <= 1'b0;
    end else begin
      r_lfsr  <= {r_lfsr[14:0], w_fb};
      r_stall <= r_lfsr[0] & r_lfsr[1];
    end
  end

  assign stall = r_stall;
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_wb_sram_responder.sv
// Self-checking bench for wb_sram_responder: per-cycle reference model of the
// memory and ack schedule, with each test comparing its own cycle window.
module tb_wb_sram_responder;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned LAT   = 3;
  localparam int unsigned AW    = 6;
  localparam int          NC    = 8192;

  logic        clk = 1'b0;
  logic        rst, stb, we;
  logic [31:0] adr, dat_w;
  logic [3:0]  sel;
  logic        stall, ack;
  logic [31:0] dat_r;

  wb_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .stb(stb), .stall(stall), .ack(ack),
    .adr(adr), .sel(sel), .we(we), .dat_w(dat_w), .dat_r(dat_r)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_m [DEPTH];
  logic        exp_ack [NC];
  logic [31:0] exp_dat [NC];
  logic        obs_ack [NC];
  logic [31:0] obs_dat [NC];
  int          ncyc = -1;
  int          vectors = 0;
  int          miscompares = 0;
  bit          stall_seen = 1'b0;

  // One clock: drive inputs in the low phase, model the edge, sample at the next negedge.
  task automatic cyc(input logic r, input logic s, input logic w, input logic [31:0] a,
                     input logic [3:0] sl, input logic [31:0] d, output logic acc, output int n);
    rst = r; stb = s; we = w; adr = a; sel = sl; dat_w = d;
    #1;
    if (stall) stall_seen = 1'b1;
    acc = s && !stall && !r;
    @(posedge clk);
    ncyc++;
    n = ncyc;
    if (n + int'(LAT) >= NC) begin
      $display("FAIL cycle_budget n=%0d limit=%0d", n, NC);
      $fatal(1);
    end
    if (r) begin
      for (int k = n; k < n + int'(LAT); k++) begin
        exp_ack[k] = 1'b0;
        exp_dat[k] = 32'h0;
      end
    end else if (acc) begin
      exp_ack[n + int'(LAT) - 1] = 1'b1;
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (sl[b]) mem_m[a[2 +: AW]][8*b +: 8] = d[8*b +: 8];
        exp_dat[n + int'(LAT) - 1] = 32'h0;
      end else begin
        exp_dat[n + int'(LAT) - 1] = mem_m[a[2 +: AW]];
      end
    end
    @(negedge clk);
    obs_ack[n] = ack;
    obs_dat[n] = dat_r;
  endtask

  task automatic idle(input int k);
    logic acc;
    int   n;
    for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, acc, n);
  endtask

  // Holds stb until accepted; returns the accept cycle or -1 on timeout.
  task automatic req(input logic w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, output int n_acc);
    logic acc;
    int   n;
    n_acc = -1;
    for (int t = 0; t < 64; t++) begin
      cyc(1'b0, 1'b1, w, a, s, d, acc, n);
      if (acc) begin
        n_acc = n;
        break;
      end
    end
    if (n_acc < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL req_timeout adr=%h got no accept, required accept within 64 cycles", a);
    end
  endtask

  task automatic test_reset();
    logic acc;
    int   n;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0, acc, n);
    vectors++;
    if (obs_ack[n] !== 1'b0) begin
      miscompares++; $display("FAIL reset_ack got %b required 0", obs_ack[n]);
    end
    vectors++;
    if (obs_dat[n] !== 32'h0) begin
      miscompares++; $display("FAIL reset_dat got %h required 0", obs_dat[n]);
    end
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++; $display("FAIL reset_stall got %b required 0", stall);
    end
  endtask

  task automatic test_fill();
    int c0, n;
    c0 = ncyc + 1;
    for (int i = 0; i < int'(DEPTH); i++) req(1'b1, 32'(i * 4), 4'hF, $urandom, n);
    idle(LAT);
    for (int k = c0; k <= ncyc; k++) begin
      vectors++;
      if (obs_ack[k] !== exp_ack[k] || obs_dat[k] !== exp_dat[k]) begin
        miscompares++;
        $display("FAIL fill cyc=%0d got ack=%b dat=%h required ack=%b dat=%h",
                 k, obs_ack[k], obs_dat[k], exp_ack[k], exp_dat[k]);
      end
    end
  endtask

  task automatic test_raw();
    int c0, nw, nr;
    c0 = ncyc + 1;
    req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, nw);
    req(1'b0, 32'h10, 4'h0, 32'h0, nr);
    req(1'b1, 32'h14, 4'hF, 32'h11223344, nw);
    req(1'b1, 32'h14, 4'b0101, 32'hAABBCCDD, nw);
    req(1'b0, 32'h14, 4'h0, 32'h0, nr);
    idle(LAT);
    for (int k = c0; k <= ncyc; k++) begin
      vectors++;
      if (obs_ack[k] !== exp_ack[k] || obs_dat[k] !== exp_dat[k]) begin
        miscompares++;
        $display("FAIL raw cyc=%0d got ack=%b dat=%h required ack=%b dat=%h",
                 k, obs_ack[k], obs_dat[k], exp_ack[k], exp_dat[k]);
      end
    end
    vectors++;
    if (obs_dat[nr + int'(LAT) - 1] !== 32'h11BB33DD || obs_ack[nr + int'(LAT) - 1] !== 1'b1) begin
      miscompares++;
      $display("FAIL byte_lanes got ack=%b dat=%h required ack=1 dat=11bb33dd",
               obs_ack[nr + int'(LAT) - 1], obs_dat[nr + int'(LAT) - 1]);
    end
  endtask

  task automatic test_back_to_back();
    int c0, n, first;
    c0 = ncyc + 1;
    first = -1;
    for (int i = 0; i < 8; i++) begin
      req(1'b0, 32'(i * 4), 4'h0, 32'h0, n);
      if (i == 0) first = n;
    end
    idle(LAT);
    for (int k = c0; k <= ncyc; k++) begin
      vectors++;
      if (obs_ack[k] !== exp_ack[k] || obs_dat[k] !== exp_dat[k]) begin
        miscompares++;
        $display("FAIL b2b cyc=%0d got ack=%b dat=%h required ack=%b dat=%h",
                 k, obs_ack[k], obs_dat[k], exp_ack[k], exp_dat[k]);
      end
    end
    vectors++;
    if (obs_dat[first + int'(LAT) - 1] !== mem_m[0] || obs_ack[first + int'(LAT) - 1] !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first got ack=%b dat=%h required ack=1 dat=%h",
               obs_ack[first + int'(LAT) - 1], obs_dat[first + int'(LAT) - 1], mem_m[0]);
    end
  endtask

  task automatic test_wrap();
    int c0, n, nr;
    logic [31:0] d;
    c0 = ncyc + 1;
    d = $urandom;
    req(1'b1, 32'h1000_0004, 4'hF, d, n);
    req(1'b0, 32'h0000_0004, 4'h0, 32'h0, nr);
    idle(LAT);
    for (int k = c0; k <= ncyc; k++) begin
      vectors++;
      if (obs_ack[k] !== exp_ack[k] || obs_dat[k] !== exp_dat[k]) begin
        miscompares++;
        $display("FAIL wrap cyc=%0d got ack=%b dat=%h required ack=%b dat=%h",
                 k, obs_ack[k], obs_dat[k], exp_ack[k], exp_dat[k]);
      end
    end
    vectors++;
    if (obs_dat[nr + int'(LAT) - 1] !== d) begin
      miscompares++;
      $display("FAIL wrap_data got %h required %h", obs_dat[nr + int'(LAT) - 1], d);
    end
  endtask

  task automatic test_reset_drop();
    int c0, n, nrst;
    logic acc;
    c0 = ncyc + 1;
    req(1'b0, 32'h8, 4'h0, 32'h0, n);
    req(1'b0, 32'hC, 4'h0, 32'h0, n);
    cyc(1'b1, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, acc, nrst);
    idle(LAT + 2);
    for (int k = c0; k <= ncyc; k++) begin
      vectors++;
      if (obs_ack[k] !== exp_ack[k] || obs_dat[k] !== exp_dat[k]) begin
        miscompares++;
        $display("FAIL rst_drop cyc=%0d got ack=%b dat=%h required ack=%b dat=%h",
                 k, obs_ack[k], obs_dat[k], exp_ack[k], exp_dat[k]);
      end
    end
    vectors++;
    if (obs_ack[nrst] !== 1'b0 || obs_dat[nrst] !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_drop_after got ack=%b dat=%h required ack=0 dat=0", obs_ack[nrst], obs_dat[nrst]);
    end
  endtask

  task automatic test_random();
    int c0, n, accepts, acks;
    c0 = ncyc + 1;
    accepts = 0;
    acks = 0;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(3) == 0) idle(1);
      else begin
        req(1'($urandom), $urandom, 4'($urandom), $urandom, n);
        if (n >= 0) accepts++;
      end
    end
    idle(LAT);
    for (int k = c0; k <= ncyc; k++) begin
      if (obs_ack[k] === 1'b1) acks++;
      vectors++;
      if (obs_ack[k] !== exp_ack[k] || obs_dat[k] !== exp_dat[k]) begin
        miscompares++;
        $display("FAIL random cyc=%0d got ack=%b dat=%h required ack=%b dat=%h",
                 k, obs_ack[k], obs_dat[k], exp_ack[k], exp_dat[k]);
      end
    end
    vectors++;
    if (acks != accepts) begin
      miscompares++;
      $display("FAIL ack_count got %0d required %0d", acks, accepts);
    end
`ifdef WB_RESPONDER_STALL_INJECT_EN
    vectors++;
    if (!stall_seen) begin
      miscompares++;
      $display("FAIL stall_seen got 0 required 1");
    end
`else
    vectors++;
    if (stall_seen) begin
      miscompares++;
      $display("FAIL stall_tied got 1 required 0");
    end
`endif
  endtask

  initial begin
    for (int k = 0; k < NC; k++) begin
      exp_ack[k] = 1'b0;
      exp_dat[k] = 32'h0;
      obs_ack[k] = 1'b0;
      obs_dat[k] = 32'h0;
    end
    for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = 32'h0;
    rst = 1'b1; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat_w = '0;
    test_reset();
    test_fill();
    test_raw();
    test_back_to_back();
    test_wrap();
    test_reset_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
